nh_window_sched: RTL
====================

NH_WINDOW_SCHED -- requirements
Module: nh_window_sched

Interface
REQ-001 The block SHALL have parameter NH_DIM, default 3, meaning neighborhood edge length in pixels.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 32, meaning pixels per line.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 32, meaning lines per frame.
REQ-004 The block SHALL have parameter STRIDE, default 1, meaning window step in both axes (1..NH_DIM).
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, a one-cycle request to begin a frame.
REQ-008 The block SHALL have port pix_valid, input, 1, meaning an upstream pixel is offered.
REQ-009 The block SHALL have port pix_ready, output, 1, meaning the block accepts the pixel this cycle.
REQ-010 The block SHALL have port shift_en, output, 1, the advance strobe to the neighborhood shift register, equal to pix_valid & pix_ready.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream consumes the current window.
REQ-012 The block SHALL have port win_valid, output, 1, meaning the shift register holds a complete in-bounds window.
REQ-013 The block SHALL have port win_row, output, clog2(IMG_HEIGHT), the top row of the current window.
REQ-014 The block SHALL have port win_col, output, clog2(IMG_WIDTH), the left column of the current window.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port frame_done, output, 1, a one-cycle pulse at frame completion.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, DRAIN and DONE.
- IDLE->STREAM on start.
- STREAM->DRAIN on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- DRAIN->DONE when win_valid is 0, or when win_valid&out_ready.
- DONE->IDLE unconditionally after 1 cycle.
REQ-018 pix_ready SHALL be (state==STREAM) && (!win_valid || out_ready).
REQ-019 Pixel column/row counters SHALL track the accepted pixel; column wraps IMG_WIDTH-1->0 with row+1; both clear on entry to STREAM.
REQ-020 An accepted pixel at (r,c) SHALL be window-completing iff r>=NH_DIM-1, c>=NH_DIM-1, (r-NH_DIM+1) mod STRIDE==0 and (c-NH_DIM+1) mod STRIDE==0.
REQ-021 Modulo SHALL be realized with stride phase counters; no divider.
REQ-022 win_valid SHALL rise in the cycle after a completing accept (latency 1), with win_row=r-NH_DIM+1 and win_col=c-NH_DIM+1 registered alongside.
REQ-023 Windows straddling a line wrap (c<NH_DIM-1) SHALL never be flagged.
REQ-024 win_valid SHALL clear on out_ready unless a completing accept occurs in the same cycle, in which case it SHALL stay 1 with the new coordinates.
REQ-025 win_row/win_col SHALL hold while win_valid=1 and out_ready=0.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 pix_valid SHALL be ignored outside STREAM.
REQ-028 frame_done SHALL be high exactly in DONE.

Reset
REQ-029 On reset=0, asynchronously:
- state SHALL go to IDLE.
- All counters SHALL clear.
- pix_ready, shift_en, win_valid, busy and frame_done SHALL be 0.
- win_row and win_col SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the frame, and the block SHALL require a new start.

Structure
REQ-031 Package nh_pkg SHALL hold NH_DIM, the FSM state typedef and the coordinate width constants.
REQ-032 Sub-module nh_pos_counter SHALL implement the row/column counters with stride phase and the completing flag; the FSM and window registers SHALL stay in the top level.

Verification
REQ-033 NH_DIM=3, 5x5, STRIDE=1, out_ready=1, continuous pix_valid -> 9 windows; first window win_valid the cycle after accept #13 with (0,0); last window (2,2); frame_done 1 cycle later.
REQ-034 Same geometry, STRIDE=2 -> exactly 4 windows: (0,0), (0,2), (2,0), (2,2).
REQ-035 out_ready=0 for 5 cycles while win_valid -> pix_ready=0 and shift_en=0 throughout; coordinates hold; no pixel lost after release.
REQ-036 out_ready=1 with a completing accept in the same cycle -> win_valid stays 1 and coordinates advance (0,0)->(0,1).
REQ-037 reset pulled low after 10 accepts -> all outputs 0 immediately; pix_valid with no start -> pix_ready stays 0.
REQ-038 start pulsed during STREAM -> ignored; counters continue and the window count is unchanged.

Source files
------------

// File: rtl/nh_pkg.sv
// Shared definitions for the neighborhood window scheduler.
// Holds the default neighborhood size and image geometry, the FSM state
// type, the coordinate width constants and a width helper.
package nh_pkg;

  // Neighborhood edge length in pixels (default for NH_DIM).
  localparam int NH_DIM_DEF     = 3;
  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W_DEF = coord_w(IMG_HEIGHT_DEF);
  localparam int COL_W_DEF = coord_w(IMG_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } nh_state_e;

endpackage

// File: rtl/nh_window_sched_pos_counter.sv
// nh_pos_counter: row/column position of the next accepted pixel, plus
// stride phase counters that replace the modulo tests on window origins.
// Ports:
//   clock, reset   - clock, async active-low reset
//   clear          - synchronous restart of all counters (frame start)
//   adv            - a pixel is accepted this cycle
//   last           - current position is the final pixel of the frame
//   complete       - the pixel accepted this cycle completes a window
//   win_row_nxt    - top row of the window that pixel would complete
//   win_col_nxt    - left column of the window that pixel would complete
module nh_pos_counter
  import nh_pkg::*;
#(
  parameter int NH_DIM     = NH_DIM_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int STRIDE     = 1,
  parameter int ROW_W      = coord_w(IMG_HEIGHT),
  parameter int COL_W      = coord_w(IMG_WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             adv,
  output logic             last,
  output logic             complete,
  output logic [ROW_W-1:0] win_row_nxt,
  output logic [COL_W-1:0] win_col_nxt
);

  localparam int PH_W = coord_w(STRIDE);

  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_START = COL_W'(NH_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(NH_DIM - 1);
  localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(STRIDE - 1);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  // Phase = (pos - NH_DIM + 1) mod STRIDE once pos reaches NH_DIM-1;
  // held at 0 below that so it starts counting from the first valid origin.
  logic [PH_W-1:0]  row_ph;
  logic [PH_W-1:0]  col_ph;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
    end else if (clear) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
    end else if (adv) begin
      if (col == COL_MAX) begin
        col    <= '0;
        col_ph <= '0;
        row    <= (row == ROW_MAX) ? '0 : row + 1'b1;
        if (row >= ROW_START)
          row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + 1'b1;
      end else begin
        col <= col + 1'b1;
        if (col >= COL_START)
          col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + 1'b1;
      end
    end
  end

  // col >= NH_DIM-1 also rules out windows that would straddle a line wrap.
  assign complete    = adv && (row >= ROW_START) && (col >= COL_START) &&
                       (row_ph == '0) && (col_ph == '0);
  assign last        = (row == ROW_MAX) && (col == COL_MAX);
  assign win_row_nxt = row - ROW_START;
  assign win_col_nxt = col - COL_START;

endmodule

// File: rtl/nh_window_sched.sv
// nh_window_sched: frame-level scheduler for a sliding neighborhood window.
// Accepts a raster-ordered pixel stream, strobes the external shift
// register, and flags when it holds a complete in-bounds window.
// Ports:
//   clock, reset      - clock, async active-low reset
//   start             - one-cycle frame request (honoured only in IDLE)
//   pix_valid         - upstream pixel offered
//   pix_ready         - pixel accepted this cycle
//   shift_en          - shift register advance (pix_valid & pix_ready)
//   out_ready         - downstream consumes the current window
//   win_valid         - complete window available
//   win_row, win_col  - top-left coordinate of the current window
//   busy              - any state other than IDLE
//   frame_done        - one-cycle pulse at frame completion
module nh_window_sched
  import nh_pkg::*;
#(
  parameter int NH_DIM     = NH_DIM_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int STRIDE     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic                          shift_en,
  input  logic                          out_ready,
  output logic                          win_valid,
  output logic [coord_w(IMG_HEIGHT)-1:0] win_row,
  output logic [coord_w(IMG_WIDTH)-1:0]  win_col,
  output logic                          busy,
  output logic                          frame_done
);

  // state  | meaning
  // IDLE   | waiting for start
  // STREAM | accepting pixels, producing windows
  // DRAIN  | last pixel taken, waiting for the final window to be consumed
  // DONE   | one-cycle frame completion pulse

  localparam int ROW_W = coord_w(IMG_HEIGHT);
  localparam int COL_W = coord_w(IMG_WIDTH);

  nh_state_e        state;
  nh_state_e        state_nxt;
  logic             accept;
  logic             clear;
  logic             last;
  logic             complete;
  logic [ROW_W-1:0] win_row_nxt;
  logic [COL_W-1:0] win_col_nxt;

  assign pix_ready  = (state == ST_STREAM) && (!win_valid || out_ready);
  assign accept     = pix_valid && pix_ready;
  assign shift_en   = accept;
  assign clear      = (state == ST_IDLE) && start;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  nh_pos_counter #(
    .NH_DIM     (NH_DIM),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .STRIDE     (STRIDE),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_pos (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .adv         (accept),
    .last        (last),
    .complete    (complete),
    .win_row_nxt (win_row_nxt),
    .win_col_nxt (win_col_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (accept && last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!win_valid || out_ready) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A completing accept wins over consumption so back-to-back windows
  // keep win_valid high with fresh coordinates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (complete) begin
      win_valid <= 1'b1;
      win_row   <= win_row_nxt;
      win_col   <= win_col_nxt;
    end else if (out_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule
